mem_responder: RTL and testbench



---
 rtl/mem_responder.sv | 144 ++++++++++++++
 tb/tb_mem_responder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
//
// Memory-side responder for the tagged BUS_LOAD / BUS_STORE protocol.
// Accepts at most one command per cycle and answers with a nonzero
// transaction tag in the same cycle. Each accepted load returns its 64-bit
// word, with the matching tag, exactly LATENCY cycles after acceptance.
// Stores write the backing array and return no data beat.
//
// Parameters:
//   DEPTH            number of 64-bit words (power of two, at least 2)
//   LATENCY          cycles from load acceptance to data return (1..14)
//   MAX_OUTSTANDING  maximum number of loads in flight (1..15)
//
// Ports:
//   clock              system clock
//   reset              synchronous, active-high reset
//   proc2mem_command   0 = none, 1 = load, 2 = store, 3 = none
//   proc2mem_addr      byte address; bits [2:0] are ignored
//   proc2mem_data      store data
//   mem2proc_response  accepted tag this cycle, 0 = not accepted (combinational)
//   mem2proc_data      load return data, 0 whenever no beat is presented
//   mem2proc_tag       tag of the beat on mem2proc_data, 0 = no beat
// ---------------------------------------------------------------------------
`ifndef XLEN
`define XLEN 32
`endif

module mem_responder #(
   parameter int DEPTH           = 256,
   parameter int LATENCY         = 4,
   parameter int MAX_OUTSTANDING = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [1:0]        proc2mem_command,
   input  logic [`XLEN-1:0]  proc2mem_addr,
   input  logic [63:0]       proc2mem_data,
   output logic [3:0]        mem2proc_response,
   output logic [63:0]       mem2proc_data,
   output logic [3:0]        mem2proc_tag
);

   localparam int IDX_W = $clog2(DEPTH);

   localparam logic [1:0] BUS_LOAD  = 2'd1;
   localparam logic [1:0] BUS_STORE = 2'd2;

   logic [63:0]      mem [DEPTH];

   logic [`XLEN-1:0] addrWord;
   logic [IDX_W-1:0] wordIdx;
   logic             inRange;

   logic [3:0]       nextTag_q, nextTag_d;
   logic [3:0]       inflight_q, inflight_d;
   logic [3:0]       inflightLive;

   logic [3:0]       pipeTag_q  [LATENCY];
   logic [63:0]      pipeData_q [LATENCY];

   logic             presenting;
   logic             loadAccept;
   logic             storeAccept;
   logic             accept;

   // Dropping the byte offset first means every address bit feeds either
   // the word index or the range check.
   assign addrWord = proc2mem_addr >> 3;
   assign wordIdx  = addrWord[IDX_W-1:0];
   assign inRange  = ((addrWord >> IDX_W) == '0);

   // The last pipeline stage is the output register, so a nonzero tag
   // there is the beat being presented this cycle.
   assign presenting = (pipeTag_q[LATENCY-1] != 4'd0);

   // A load finishing this cycle frees its slot immediately, so a new load
   // can be accepted in the very cycle the oldest beat retires.
   assign inflightLive = inflight_q - {3'b000, presenting};

   // Accept decisions and the combinational tag response.
   always_comb begin
      loadAccept  = 1'b0;
      storeAccept = 1'b0;
      if (!reset && inRange) begin
         if (proc2mem_command == BUS_LOAD) begin
            loadAccept = (inflightLive < 4'(MAX_OUTSTANDING));
         end
         if (proc2mem_command == BUS_STORE) begin
            storeAccept = 1'b1;
         end
      end
      accept            = loadAccept | storeAccept;
      mem2proc_response = accept ? nextTag_q : 4'd0;
   end

   // Next tag and in-flight count. Tags skip zero on wrap because zero
   // means "nothing" on both response and return paths.
   always_comb begin
      nextTag_d = nextTag_q;
      if (accept) begin
         nextTag_d = (nextTag_q == 4'd15) ? 4'd1 : nextTag_q + 4'd1;
      end
      inflight_d = inflightLive + {3'b000, loadAccept};
   end

   // Tag counter, in-flight counter and the fixed-latency return pipeline.
   // A load snapshots its word at acceptance, so later stores cannot alter
   // the returned value. Empty slots carry tag 0 and data 0, which keeps
   // the data output at zero whenever no beat is presented.
   always_ff @(posedge clock) begin
      if (reset) begin
         nextTag_q  <= 4'd1;
         inflight_q <= 4'd0;
         for (int i = 0; i < LATENCY; i++) begin
            pipeTag_q[i]  <= 4'd0;
            pipeData_q[i] <= 64'd0;
         end
      end else begin
         nextTag_q  <= nextTag_d;
         inflight_q <= inflight_d;
         for (int i = 1; i < LATENCY; i++) begin
            pipeTag_q[i]  <= pipeTag_q[i-1];
            pipeData_q[i] <= pipeData_q[i-1];
         end
         pipeTag_q[0]  <= loadAccept ? nextTag_q : 4'd0;
         pipeData_q[0] <= loadAccept ? mem[wordIdx] : 64'd0;
      end
   end

   // Backing array. It is never cleared by reset; storeAccept is already
   // low during reset, so a store presented in a reset cycle is dropped.
   always_ff @(posedge clock) begin
      if (storeAccept) begin
         mem[wordIdx] <= proc2mem_data;
      end
   end

   // Outputs are forced quiet for the whole reset cycle, including the
   // first one, before the synchronous clear has taken effect.
   assign mem2proc_tag  = reset ? 4'd0  : pipeTag_q[LATENCY-1];
   assign mem2proc_data = reset ? 64'd0 : pipeData_q[LATENCY-1];

endmodule

// File: tb/tb_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_responder
//
// Self-checking bench for mem_responder. A reference model holds the
// memory contents, the next tag and a queue of promised load beats
// (due cycle, tag, data). Every cycle the bench drives one command,
// compares the response, tag and data outputs against the model, then
// advances the model. Directed scenarios come first, then random traffic.
// ---------------------------------------------------------------------------
`ifndef XLEN
`define XLEN 32
`endif

module tb_mem_responder;

   localparam int DEPTH   = 256;
   // Long enough that eight back-to-back loads reach the outstanding limit
   // before the first one returns.
   localparam int LAT     = 12;
   localparam int MAX_OUT = 8;

   localparam logic [1:0] CMD_NONE  = 2'd0;
   localparam logic [1:0] CMD_LOAD  = 2'd1;
   localparam logic [1:0] CMD_STORE = 2'd2;
   localparam logic [1:0] CMD_BAD   = 2'd3;

   logic              clock;
   logic              reset;
   logic [1:0]        proc2mem_command;
   logic [`XLEN-1:0]  proc2mem_addr;
   logic [63:0]       proc2mem_data;
   logic [3:0]        mem2proc_response;
   logic [63:0]       mem2proc_data;
   logic [3:0]        mem2proc_tag;

   mem_responder #(
      .DEPTH(DEPTH),
      .LATENCY(LAT),
      .MAX_OUTSTANDING(MAX_OUT)
   ) dut (
      .clock(clock),
      .reset(reset),
      .proc2mem_command(proc2mem_command),
      .proc2mem_addr(proc2mem_addr),
      .proc2mem_data(proc2mem_data),
      .mem2proc_response(mem2proc_response),
      .mem2proc_data(mem2proc_data),
      .mem2proc_tag(mem2proc_tag)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      int          due;
      logic [3:0]  tag;
      logic [63:0] data;
   } beat_t;

   logic [63:0] memModel [DEPTH];
   beat_t       beats [$];
   int          nextTag;
   int          cyc;
   int          checks;
   int          errors;

   // One bus cycle: drive inputs after the falling edge, compare outputs
   // against the model, then update the model and wait for the rising edge.
   task automatic applyStimulus(input logic r, input logic [1:0] cmd,
                                input logic [`XLEN-1:0] addr,
                                input logic [63:0] wdata);
      logic [3:0]  expResp;
      logic [3:0]  expTag;
      logic [63:0] expData;
      bit          legal;
      int          idx;
      int          pending;
      @(negedge clock);
      reset            = r;
      proc2mem_command = cmd;
      proc2mem_addr    = addr;
      proc2mem_data    = wdata;
      #1;
      legal   = (addr < `XLEN'(8 * DEPTH));
      idx     = int'(addr / 8) % DEPTH;
      pending = 0;
      foreach (beats[i]) if (beats[i].due > cyc) pending++;
      expTag  = 4'd0;
      expData = 64'd0;
      if (!r && beats.size() > 0 && beats[0].due == cyc) begin
         expTag  = beats[0].tag;
         expData = beats[0].data;
      end
      expResp = 4'd0;
      if (!r && legal && cmd == CMD_STORE) expResp = 4'(nextTag);
      if (!r && legal && cmd == CMD_LOAD && pending < MAX_OUT) expResp = 4'(nextTag);
      checkOutput(expResp, expTag, expData);
      if (r) begin
         beats.delete();
         nextTag = 1;
      end else begin
         if (beats.size() > 0 && beats[0].due == cyc) void'(beats.pop_front());
         if (expResp != 4'd0) begin
            if (cmd == CMD_LOAD) begin
               beats.push_back('{due: cyc + LAT, tag: expResp, data: memModel[idx]});
            end else begin
               memModel[idx] = wdata;
            end
            nextTag = (nextTag == 15) ? 1 : nextTag + 1;
         end
      end
      @(posedge clock);
      cyc++;
   endtask

   task automatic checkOutput(input logic [3:0] expResp, input logic [3:0] expTag,
                              input logic [63:0] expData);
      checks++;
      assert (mem2proc_response === expResp) else begin
         errors++;
         $error("[TB] FAIL response cyc=%0d got=%0h want=%0h", cyc, mem2proc_response, expResp);
      end
      checks++;
      assert (mem2proc_tag === expTag) else begin
         errors++;
         $error("[TB] FAIL tag cyc=%0d got=%0h want=%0h", cyc, mem2proc_tag, expTag);
      end
      checks++;
      assert (mem2proc_data === expData) else begin
         errors++;
         $error("[TB] FAIL data cyc=%0d got=%0h want=%0h", cyc, mem2proc_data, expData);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, CMD_NONE, '0, 64'd0);
   endtask

   task automatic doReset();
      applyStimulus(1'b1, CMD_NONE, '0, 64'd0);
   endtask

   initial begin
      int t0;
      checks           = 0;
      errors           = 0;
      cyc              = 0;
      nextTag          = 1;
      reset            = 1'b1;
      proc2mem_command = CMD_NONE;
      proc2mem_addr    = '0;
      proc2mem_data    = 64'd0;

      $display("[TB] reset and memory fill");
      doReset();
      doReset();
      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus(1'b0, CMD_STORE, `XLEN'(i * 8), {$urandom, $urandom});
      end
      idle(2);

      $display("[TB] store then load");
      doReset();
      applyStimulus(1'b0, CMD_STORE, `XLEN'('h10), 64'hDEADBEEF_01234567);
      applyStimulus(1'b0, CMD_LOAD, `XLEN'('h10), 64'd0);
      idle(LAT + 1);

      $display("[TB] load snapshot versus later store");
      applyStimulus(1'b0, CMD_LOAD, `XLEN'('h10), 64'd0);
      applyStimulus(1'b0, CMD_STORE, `XLEN'('h10), 64'h5);
      applyStimulus(1'b0, CMD_LOAD, `XLEN'('h10), 64'd0);
      idle(LAT + 1);

      $display("[TB] outstanding limit");
      doReset();
      t0 = cyc;
      for (int i = 0; i < MAX_OUT; i++) applyStimulus(1'b0, CMD_LOAD, `XLEN'(i * 8), 64'd0);
      applyStimulus(1'b0, CMD_LOAD, `XLEN'('h40), 64'd0);
      while (cyc < t0 + LAT) idle(1);
      applyStimulus(1'b0, CMD_LOAD, `XLEN'('h40), 64'd0);
      idle(LAT + 1);

      $display("[TB] tag wrap with stores");
      doReset();
      for (int i = 0; i < 16; i++) applyStimulus(1'b0, CMD_STORE, `XLEN'(i * 8), {$urandom, $urandom});
      applyStimulus(1'b0, CMD_LOAD, `XLEN'(5 * 8), 64'd0);
      idle(LAT + 1);

      $display("[TB] range, alias and reserved command");
      applyStimulus(1'b0, CMD_LOAD, `XLEN'(8 * DEPTH), 64'd0);
      applyStimulus(1'b0, CMD_STORE, `XLEN'(8 * DEPTH + 8), 64'h1234);
      applyStimulus(1'b0, CMD_LOAD, `XLEN'('h17), 64'd0);
      applyStimulus(1'b0, CMD_BAD, `XLEN'('h10), 64'd0);
      idle(LAT + 1);

      $display("[TB] reset with loads in flight");
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, CMD_LOAD, `XLEN'('h10), 64'd0);
      applyStimulus(1'b1, CMD_STORE, `XLEN'('h10), 64'hBAD0_BAD0);
      idle(LAT + 2);
      applyStimulus(1'b0, CMD_LOAD, `XLEN'('h10), 64'd0);
      idle(LAT + 1);

      $display("[TB] random traffic");
      for (int n = 0; n < 500; n++) begin
         logic [1:0]       cmd;
         logic [`XLEN-1:0] addr;
         bit               r;
         r    = ($urandom_range(0, 59) == 0);
         cmd  = ($urandom_range(0, 9) < 6) ? CMD_LOAD : 2'($urandom_range(0, 3));
         addr = `XLEN'($urandom_range(0, 8 * DEPTH - 1));
         if ($urandom_range(0, 9) == 0) addr = addr | `XLEN'(8 * DEPTH << $urandom_range(0, 4));
         applyStimulus(r, cmd, addr, {$urandom, $urandom});
      end
      idle(LAT + 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
